// File: rtl/alu_mc.sv
// ---------------------------------------------------------------------------
// alu_mc : multi-cycle, handshaked ALU
//
// Runs one operation at a time on WIDTH-bit operands. Logic, add/sub and the
// single-bit shift finish at the accept edge. Variable shifts move one bit per
// clock. The optional shift-add multiplier also moves one bit per clock.
//
// Optional feature macro: ALU_MUL_EN
//   defined   : opcode 9 runs the iterative multiplier (WIDTH clocks).
//   undefined : there is no multiplier hardware, and opcode 9 is illegal.
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous active-high reset
//   in_valid   a/b/opcode valid        in_ready   block can accept an op
//   a, b       operands (b = shift amount for SHRN/SHLN)
//   opcode     operation select (0..9 legal, A..F illegal)
//   out_valid  result valid            out_ready  consumer takes the result
//   y          result
//   flag_z/n/c/v  zero, negative, carry/borrow/shifted-out bit, signed overflow
//   err        illegal opcode
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for in_valid; the only state with in_ready high
// EXEC  | iterating a shift or multiply, one bit per clock
// DONE  | result held on y/flags, waiting for out_ready
// ---------------------------------------------------------------------------
module alu_mc #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       opcode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v,
    output logic             err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] OP_OR   = 4'h0;
    localparam logic [3:0] OP_AND  = 4'h1;
    localparam logic [3:0] OP_NOTA = 4'h2;
    localparam logic [3:0] OP_XOR  = 4'h3;
    localparam logic [3:0] OP_ADD  = 4'h4;
    localparam logic [3:0] OP_SUB  = 4'h5;
    localparam logic [3:0] OP_SHR1 = 4'h6;
    localparam logic [3:0] OP_SHRN = 4'h7;
    localparam logic [3:0] OP_SHLN = 4'h8;
`ifdef ALU_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'h9;
    localparam logic [SHW:0] CNT_MUL = (SHW+1)'(WIDTH);
`endif

    // b is compared one bit wider than the operand so that WIDTH itself is
    // representable even when WIDTH is a power of two.
    localparam logic [WIDTH:0] W_VAL   = (WIDTH+1)'(WIDTH);
    localparam logic [SHW:0]   CNT_ONE = (SHW+1)'(1);

    state_t state, state_nxt;

    logic             accept;
    logic             exec_last;

    logic [3:0]       op_r;
    logic [SHW:0]     cnt;
    logic [WIDTH-1:0] wrk;
    logic [WIDTH-1:0] wrk_nxt;
    logic [WIDTH-1:0] res_exec;
    logic             c_nxt;

    logic [WIDTH-1:0] res_d;
    logic             c_d;
    logic             v_d;
    logic             err_d;
    logic             multi_d;
    logic [SHW:0]     cnt_d;
    logic             shamt_big;
    logic             shamt_eq;

`ifdef ALU_MUL_EN
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;
    logic [WIDTH-1:0] mpl;
    logic [WIDTH-1:0] mpl_nxt;
`endif

    assign in_ready  = (state == S_IDLE) && !rst;
    assign accept    = in_valid && in_ready;
    assign out_valid = (state == S_DONE);
    assign exec_last = (state == S_EXEC) && (cnt == CNT_ONE);

    // ------------------------------------------------------------------
    // Accept-edge decode: single-cycle results and the setup for
    // the iterative ops.
    // ------------------------------------------------------------------
    always_comb begin
        res_d     = '0;
        c_d       = 1'b0;
        v_d       = 1'b0;
        err_d     = 1'b0;
        multi_d   = 1'b0;
        cnt_d     = '0;
        shamt_big = ({1'b0, b} >= W_VAL);
        shamt_eq  = ({1'b0, b} == W_VAL);
        case (opcode)
            OP_OR:   res_d = a | b;
            OP_AND:  res_d = a & b;
            OP_NOTA: res_d = ~a;
            OP_XOR:  res_d = a ^ b;
            OP_ADD: begin
                {c_d, res_d} = {1'b0, a} + {1'b0, b};
                v_d = (a[WIDTH-1] == b[WIDTH-1]) && (res_d[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res_d = a - b;
                c_d   = (a < b);
                v_d   = (a[WIDTH-1] != b[WIDTH-1]) && (res_d[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SHR1: begin
                res_d = a >> 1;
                c_d   = a[0];
            end
            OP_SHRN: begin
                if (b == '0) begin
                    res_d = a;
                end else if (shamt_big) begin
                    res_d = '0;
                    c_d   = shamt_eq & a[WIDTH-1];
                end else begin
                    multi_d = 1'b1;
                    cnt_d   = {1'b0, b[SHW-1:0]};
                end
            end
            OP_SHLN: begin
                if (b == '0) begin
                    res_d = a;
                end else if (shamt_big) begin
                    res_d = '0;
                    c_d   = shamt_eq & a[0];
                end else begin
                    multi_d = 1'b1;
                    cnt_d   = {1'b0, b[SHW-1:0]};
                end
            end
`ifdef ALU_MUL_EN
            OP_MUL: begin
                multi_d = 1'b1;
                cnt_d   = CNT_MUL;
            end
`endif
            default: err_d = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------
    // One EXEC step. For shifts, wrk is the value being shifted. For
    // multiply, wrk is the multiplicand, which moves left each step.
    // ------------------------------------------------------------------
    always_comb begin
        wrk_nxt = wrk;
        c_nxt   = 1'b0;
        case (op_r)
            OP_SHRN: begin
                wrk_nxt = wrk >> 1;
                c_nxt   = wrk[0];
            end
            OP_SHLN: begin
                wrk_nxt = wrk << 1;
                c_nxt   = wrk[WIDTH-1];
            end
            default: ;
        endcase
        res_exec = wrk_nxt;
`ifdef ALU_MUL_EN
        acc_nxt = acc;
        mpl_nxt = mpl;
        if (op_r == OP_MUL) begin
            wrk_nxt = wrk << 1;
            mpl_nxt = mpl >> 1;
            if (mpl[0]) begin
                acc_nxt = acc + wrk;
            end
            res_exec = acc_nxt;
        end
`endif
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = multi_d ? S_EXEC : S_DONE;
                end
            end
            S_EXEC: begin
                if (cnt == CNT_ONE) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath. Outputs are written only at completion, so they stay
    // frozen while DONE waits on out_ready.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            y      <= '0;
            flag_z <= 1'b0;
            flag_n <= 1'b0;
            flag_c <= 1'b0;
            flag_v <= 1'b0;
            err    <= 1'b0;
            op_r   <= '0;
            cnt    <= '0;
            wrk    <= '0;
`ifdef ALU_MUL_EN
            acc    <= '0;
            mpl    <= '0;
`endif
        end else if (accept) begin
            op_r <= opcode;
            cnt  <= cnt_d;
            wrk  <= a;
`ifdef ALU_MUL_EN
            acc  <= '0;
            mpl  <= b;
`endif
            if (!multi_d) begin
                y      <= res_d;
                flag_z <= (res_d == '0);
                flag_n <= res_d[WIDTH-1];
                flag_c <= c_d;
                flag_v <= v_d;
                err    <= err_d;
            end
        end else if (state == S_EXEC) begin
            cnt <= cnt - CNT_ONE;
            wrk <= wrk_nxt;
`ifdef ALU_MUL_EN
            acc <= acc_nxt;
            mpl <= mpl_nxt;
`endif
            if (exec_last) begin
                y      <= res_exec;
                flag_z <= (res_exec == '0);
                flag_n <= res_exec[WIDTH-1];
                flag_c <= c_nxt;
                flag_v <= 1'b0;
                err    <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed bench for alu_mc at WIDTH=8. Expected values are hand-computed;
// flag vectors are packed as {z, n, c, v, err}.
module tb_alu_mc;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [3:0]   opcode;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] y;
    logic         flag_z, flag_n, flag_c, flag_v, err;

    int n_cmp = 0;
    int n_mis = 0;

    alu_mc #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .opcode    (opcode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .y         (y),
        .flag_z    (flag_z),
        .flag_n    (flag_n),
        .flag_c    (flag_c),
        .flag_v    (flag_v),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4:0] flags();
        return {flag_z, flag_n, flag_c, flag_v, err};
    endfunction

    // Issue one op with out_ready held high, then measure latency and
    // check the result and the transfer.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [W-1:0] ia, input logic [W-1:0] ib,
                          input logic [W-1:0] ey, input logic [4:0] ef,
                          input int ek);
        int k;
        @(negedge clk);
        opcode    = op;
        a         = ia;
        b         = ib;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        chk({tag, ".in_ready"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a        = 8'h5C;
        b        = 8'hE3;
        k        = 1;
        while (!out_valid && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk({tag, ".k"},     32'(k),     32'(ek));
        chk({tag, ".y"},     32'(y),     32'(ey));
        chk({tag, ".flags"}, 32'(flags()), 32'(ef));
        @(posedge clk);
        #1;
        chk({tag, ".ov_fall"}, 32'(out_valid), 32'd0);
        chk({tag, ".ir_rise"}, 32'(in_ready),  32'd1);
    endtask

    initial begin
        int seen;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        a         = '0;
        b         = '0;
        opcode    = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst.in_ready",  32'(in_ready),  32'd0);
        chk("rst.out_valid", 32'(out_valid), 32'd0);
        chk("rst.y",         32'(y),         32'd0);
        chk("rst.flags",     32'(flags()),   32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst.in_ready", 32'(in_ready), 32'd1);

        //      tag        op     a      b      y      {z,n,c,v,e}  k
        run_op("add_ff01", 4'h4, 8'hFF, 8'h01, 8'h00, 5'b10100, 1);
        run_op("add_7f01", 4'h4, 8'h7F, 8'h01, 8'h80, 5'b01010, 1);
        run_op("sub_8001", 4'h5, 8'h80, 8'h01, 8'h7F, 5'b00010, 1);
        run_op("sub_0102", 4'h5, 8'h01, 8'h02, 8'hFF, 5'b01100, 1);
        run_op("or",       4'h0, 8'hA0, 8'h05, 8'hA5, 5'b01000, 1);
        run_op("and",      4'h1, 8'hF0, 8'h3C, 8'h30, 5'b00000, 1);
        run_op("nota",     4'h2, 8'h0F, 8'h00, 8'hF0, 5'b01000, 1);
        run_op("xor",      4'h3, 8'hA5, 8'h0F, 8'hAA, 5'b01000, 1);
        run_op("shr1",     4'h6, 8'h03, 8'h00, 8'h01, 5'b00100, 1);
        run_op("shrn_3",   4'h7, 8'hB4, 8'h03, 8'h16, 5'b00100, 4);
        run_op("shrn_0",   4'h7, 8'h5A, 8'h00, 8'h5A, 5'b00000, 1);
        run_op("shrn_8",   4'h7, 8'h81, 8'h08, 8'h00, 5'b10100, 1);
        run_op("shln_9",   4'h8, 8'h81, 8'h09, 8'h00, 5'b10000, 1);
        run_op("shln_8",   4'h8, 8'h81, 8'h08, 8'h00, 5'b10100, 1);
        run_op("shln_1",   4'h8, 8'h03, 8'h01, 8'h06, 5'b00000, 2);
        run_op("shln_7",   4'h8, 8'h03, 8'h07, 8'h80, 5'b01100, 8);
`ifdef ALU_MUL_EN
        run_op("mul",      4'h9, 8'h0D, 8'h0B, 8'h8F, 5'b01000, 9);
`else
        run_op("op9_ill",  4'h9, 8'h0D, 8'h0B, 8'h00, 5'b10001, 1);
`endif
        run_op("op_f_ill", 4'hF, 8'h12, 8'h34, 8'h00, 5'b10001, 1);

        // Backpressure: result held, busy input ignored, one transfer on release.
        @(negedge clk);
        opcode    = 4'h4;
        a         = 8'h12;
        b         = 8'h34;
        in_valid  = 1'b1;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        opcode = 4'hF;
        a      = 8'hFF;
        b      = 8'hFF;
        chk("bp.ov", 32'(out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("bp.hold_y",  32'(y),         32'h46);
            chk("bp.hold_f",  32'(flags()),   32'd0);
            chk("bp.hold_ir", 32'(in_ready),  32'd0);
            chk("bp.hold_ov", 32'(out_valid), 32'd1);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp.rel_ov", 32'(out_valid), 32'd0);
        chk("bp.rel_ir", 32'(in_ready),  32'd1);
        @(posedge clk);
        #1;
        chk("bp.no_ghost", 32'(out_valid), 32'd0);
        chk("bp.y_kept",   32'(y),         32'h46);

        // Reset during a long EXEC: the op is dropped and no out_valid appears.
        @(negedge clk);
`ifdef ALU_MUL_EN
        opcode = 4'h9;
        a      = 8'h0D;
        b      = 8'h0B;
`else
        opcode = 4'h8;
        a      = 8'h01;
        b      = 8'h07;
`endif
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        chk("abort.no_ov", 32'(seen), 32'd0);
        chk("abort.y",     32'(y),    32'd0);
        run_op("add_after_rst", 4'h4, 8'h05, 8'h03, 8'h08, 5'b00000, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
